// File: rtl/instruction_loader_if.sv
// ---------------------------------------------------------------------------
// instruction_loader_if
// Bundles the loader's session control, byte stream and memory write port.
//   master : the side that starts sessions, feeds bytes and owns the memory
//            (drives start/base_addr/word_count/byte_in/byte_valid)
//   slave  : the loader itself (drives byte_ready, mem_*, busy, done,
//            words_loaded)
// ---------------------------------------------------------------------------
interface instruction_loader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [ADDR_WIDTH:0]   word_count;
   logic [7:0]            byte_in;
   logic                  byte_valid;
   logic                  byte_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH:0]   words_loaded;

   modport master (
      output start, base_addr, word_count, byte_in, byte_valid,
      input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, words_loaded
   );

   modport slave (
      input  start, base_addr, word_count, byte_in, byte_valid,
      output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, words_loaded
   );
endinterface

// File: rtl/instruction_loader.sv
// ---------------------------------------------------------------------------
// instruction_loader
// Assembles a byte stream (first byte = most significant) into instruction
// words and writes them to consecutive word addresses of an instruction
// memory, starting at base_addr and wrapping modulo 2^ADDR_WIDTH.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset, highest priority
//   bus  - instruction_loader_if.slave:
//          start/base_addr/word_count : session request (IDLE only)
//          byte_in/byte_valid/byte_ready : byte stream handshake
//          mem_we/mem_addr/mem_wdata  : memory write port (one-cycle strobe)
//          busy/done/words_loaded     : session status
// All outputs are registered; one word takes 4 RECV cycles + 1 WRITE cycle.
// ---------------------------------------------------------------------------
module instruction_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 256,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   instruction_loader_if.slave  bus
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int IDX_W = $clog2(BYTES);
   localparam int CNT_W = $clog2(MEM_DEPTH) + 1;   // holds 0..MEM_DEPTH

   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_e;

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [CNT_W-1:0]      remaining_q;
   logic [ADDR_WIDTH:0]   loaded_q;
   logic [IDX_W-1:0]      idx_q;
   // Only the bytes received before the last one need storage: the final
   // byte is merged straight into mem_wdata on the accepting edge.
   logic [DATA_WIDTH-9:0] word_q;
   logic [DATA_WIDTH-1:0] word_d;

   logic                  byte_ready_q;
   logic                  mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic                  busy_q;
   logic                  done_q;

   assign word_d = {word_q, bus.byte_in};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         remaining_q  <= '0;
         loaded_q     <= '0;
         idx_q        <= '0;
         word_q       <= '0;
         byte_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  addr_q      <= bus.base_addr;
                  remaining_q <= bus.word_count;
                  loaded_q    <= '0;
                  idx_q       <= '0;
                  busy_q      <= 1'b1;
                  if (bus.word_count == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q      <= RECV;
                     byte_ready_q <= 1'b1;
                  end
               end
            end
            RECV: begin
               // byte_ready is always 1 here, so byte_valid alone means accept
               if (bus.byte_valid) begin
                  word_q <= word_d[DATA_WIDTH-9:0];
                  if (idx_q == IDX_W'(BYTES - 1)) begin
                     idx_q        <= '0;
                     state_q      <= WRITE;
                     byte_ready_q <= 1'b0;
                     mem_we_q     <= 1'b1;
                     mem_addr_q   <= addr_q;
                     mem_wdata_q  <= word_d;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            WRITE: begin
               mem_we_q    <= 1'b0;
               addr_q      <= addr_q + 1'b1;   // natural wrap at 2^ADDR_WIDTH
               loaded_q    <= loaded_q + 1'b1;
               remaining_q <= remaining_q - 1'b1;
               if (remaining_q == CNT_W'(1)) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q      <= RECV;
                  byte_ready_q <= 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.byte_ready   = byte_ready_q;
   assign bus.mem_we       = mem_we_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wdata    = mem_wdata_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.words_loaded = loaded_q;

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instruction_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus();
   instruction_loader #(.DATA_WIDTH(32), .MEM_DEPTH(256), .ADDR_WIDTH(8))
      dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [7:0]  a;
      logic [31:0] d;
      int          c;   // cycle the strobe was seen
      int          l;   // cycle of the most recent byte acceptance
   } wr_t;

   wr_t         wq[$];
   logic [31:0] wl[$];          // words to send in the next session
   int cyc = 0, last_acc = -1, acc_cnt = 0, done_cnt = 0, done_cyc = 0;
   int tmo = 0, start_cyc = 0;
   int n_cmp = 0, n_err = 0;

   // acceptance observed with pre-edge values; cycle index advances per edge
   always @(posedge clk) begin
      if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) begin
         acc_cnt++;
         last_acc = cyc;
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) wq.push_back('{bus.mem_addr, bus.mem_wdata, cyc, last_acc});
      if (bus.done === 1'b1) begin done_cnt++; done_cyc = cyc; end
   end

   task automatic start_session(input logic [7:0] base, input logic [8:0] cnt);
      @(negedge clk);
      bus.start = 1'b1; bus.base_addr = base; bus.word_count = cnt;
      start_cyc = cyc;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.byte_in = b; bus.byte_valid = 1'b1;
      while (bus.byte_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) tmo++;
      @(negedge clk);
      bus.byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int stall_max);
      for (int b = 0; b < 4; b++) begin
         int k = $urandom_range(stall_max, 0);
         for (int s = 0; s < k; s++) @(negedge clk);
         send_byte(w[31-8*b -: 8]);
      end
   endtask

   task automatic wait_done(input int d0);
      int n = 0;
      while (done_cnt == d0 && n < 100) begin @(negedge clk); n++; end
      if (done_cnt == d0) tmo++;
   endtask

   task automatic run_session(input logic [7:0] base, input logic [8:0] cnt, input int stall_max);
      int d0 = done_cnt;
      start_session(base, cnt);
      foreach (wl[i]) send_word(wl[i], stall_max);
      wait_done(d0);
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.start = 1'b1; bus.word_count = 9'd1;   // start must lose to rst
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      n_cmp++; if (bus.byte_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", bus.byte_ready); end
      n_cmp++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL reset_we got %b want 0", bus.mem_we); end
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done); end
      n_cmp++; if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 32'h0)
         begin n_err++; $display("FAIL reset_bus got %h/%h want 00/00000000", bus.mem_addr, bus.mem_wdata); end
      n_cmp++; if (bus.words_loaded !== 9'd0) begin n_err++; $display("FAIL reset_loaded got %0d want 0", bus.words_loaded); end
      bus.start = 1'b0; rst = 1'b0;
   endtask

   task automatic test_single_word();
      int d0 = done_cnt;
      wq.delete(); wl.delete(); wl.push_back(32'h0044_3000); tmo = 0;
      run_session(8'h00, 9'd1, 0);
      n_cmp++; if (tmo !== 0) begin n_err++; $display("FAIL single_timeout got %0d want 0", tmo); end
      n_cmp++; if (wq.size() !== 1) begin n_err++; $display("FAIL single_nwrites got %0d want 1", wq.size()); end
      else begin
         n_cmp++; if (wq[0].a !== 8'h00 || wq[0].d !== 32'h0044_3000)
            begin n_err++; $display("FAIL single_write got %h:%h want 00:00443000", wq[0].a, wq[0].d); end
         n_cmp++; if (wq[0].c !== wq[0].l + 1) begin n_err++; $display("FAIL single_latency got %0d want 1", wq[0].c - wq[0].l); end
         n_cmp++; if (done_cyc !== wq[0].c + 1) begin n_err++; $display("FAIL single_done_cycle got %0d want %0d", done_cyc, wq[0].c + 1); end
      end
      n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL single_done_pulses got %0d want 1", done_cnt - d0); end
      n_cmp++; if (bus.words_loaded !== 9'd1) begin n_err++; $display("FAIL single_loaded got %0d want 1", bus.words_loaded); end
   endtask

   task automatic test_wrap();
      logic [7:0] ea [3] = '{8'hFE, 8'hFF, 8'h00};
      wq.delete(); wl.delete(); tmo = 0;
      wl.push_back(32'h9000_0023); wl.push_back(32'h0044_3000); wl.push_back(32'h0000_0000);
      run_session(8'hFE, 9'd3, 0);
      n_cmp++; if (tmo !== 0) begin n_err++; $display("FAIL wrap_timeout got %0d want 0", tmo); end
      n_cmp++; if (wq.size() !== 3) begin n_err++; $display("FAIL wrap_nwrites got %0d want 3", wq.size()); end
      else for (int i = 0; i < 3; i++) begin
         n_cmp++; if (wq[i].a !== ea[i] || wq[i].d !== wl[i])
            begin n_err++; $display("FAIL wrap_write%0d got %h:%h want %h:%h", i, wq[i].a, wq[i].d, ea[i], wl[i]); end
      end
      n_cmp++; if (bus.words_loaded !== 9'd3) begin n_err++; $display("FAIL wrap_loaded got %0d want 3", bus.words_loaded); end
   endtask

   task automatic test_stall();
      logic [31:0] w = $urandom;
      int acc0 = acc_cnt, d0 = done_cnt, bad = 0;
      wq.delete(); tmo = 0;
      start_session(8'h55, 9'd1);
      for (int b = 0; b < 4; b++) begin
         for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            if (bus.byte_ready !== 1'b1) bad++;
         end
         send_byte(w[31-8*b -: 8]);
      end
      wait_done(d0);
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stall_ready_drop got %0d want 0", bad); end
      n_cmp++; if (acc_cnt - acc0 !== 4) begin n_err++; $display("FAIL stall_accepts got %0d want 4", acc_cnt - acc0); end
      n_cmp++; if (wq.size() !== 1) begin n_err++; $display("FAIL stall_nwrites got %0d want 1", wq.size()); end
      else begin
         n_cmp++; if (wq[0].a !== 8'h55 || wq[0].d !== w)
            begin n_err++; $display("FAIL stall_write got %h:%h want 55:%h", wq[0].a, wq[0].d, w); end
      end
      n_cmp++; if (tmo !== 0) begin n_err++; $display("FAIL stall_timeout got %0d want 0", tmo); end
   endtask

   task automatic test_zero_count();
      int d0 = done_cnt;
      wq.delete(); wl.delete(); tmo = 0;
      run_session(8'h77, 9'd0, 0);
      repeat (3) @(negedge clk);
      n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL zero_done_pulses got %0d want 1", done_cnt - d0); end
      n_cmp++; if (done_cyc - start_cyc < 1 || done_cyc - start_cyc > 2)
         begin n_err++; $display("FAIL zero_done_delay got %0d want 1..2", done_cyc - start_cyc); end
      n_cmp++; if (wq.size() !== 0) begin n_err++; $display("FAIL zero_nwrites got %0d want 0", wq.size()); end
      n_cmp++; if (bus.words_loaded !== 9'd0) begin n_err++; $display("FAIL zero_loaded got %0d want 0", bus.words_loaded); end
   endtask

   task automatic test_reset_mid_word();
      wq.delete(); wl.delete(); tmo = 0;
      start_session(8'h33, 9'd2);
      send_byte(8'hAB); send_byte(8'hCD);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if ({bus.busy, bus.byte_ready, bus.mem_we, bus.done} !== 4'b0000)
         begin n_err++; $display("FAIL midrst_flags got %b want 0000", {bus.busy, bus.byte_ready, bus.mem_we, bus.done}); end
      n_cmp++; if (bus.words_loaded !== 9'd0 || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 32'h0)
         begin n_err++; $display("FAIL midrst_values got %0d/%h/%h want 0/00/00000000", bus.words_loaded, bus.mem_addr, bus.mem_wdata); end
      repeat (4) @(negedge clk);
      n_cmp++; if (wq.size() !== 0) begin n_err++; $display("FAIL midrst_nowrite got %0d want 0", wq.size()); end
      wl.push_back(32'h9000_0023);
      run_session(8'h10, 9'd1, 1);
      n_cmp++; if (wq.size() !== 1) begin n_err++; $display("FAIL midrst_nwrites got %0d want 1", wq.size()); end
      else begin
         n_cmp++; if (wq[0].a !== 8'h10 || wq[0].d !== 32'h9000_0023)
            begin n_err++; $display("FAIL midrst_write got %h:%h want 10:90000023", wq[0].a, wq[0].d); end
      end
   endtask

   task automatic test_start_while_busy();
      logic [31:0] w0 = $urandom, w1 = $urandom;
      int d0 = done_cnt;
      wq.delete(); tmo = 0;
      start_session(8'h20, 9'd2);
      send_byte(w0[31:24]);
      bus.start = 1'b1; bus.base_addr = 8'h40; bus.word_count = 9'd5;
      @(negedge clk);
      bus.start = 1'b0;
      send_byte(w0[23:16]); send_byte(w0[15:8]); send_byte(w0[7:0]);
      bus.start = 1'b1;               // also lands in the WRITE cycle
      @(negedge clk);
      bus.start = 1'b0;
      send_word(w1, 0);
      wait_done(d0);
      n_cmp++; if (wq.size() !== 2) begin n_err++; $display("FAIL busy_nwrites got %0d want 2", wq.size()); end
      else begin
         n_cmp++; if (wq[0].a !== 8'h20 || wq[0].d !== w0)
            begin n_err++; $display("FAIL busy_write0 got %h:%h want 20:%h", wq[0].a, wq[0].d, w0); end
         n_cmp++; if (wq[1].a !== 8'h21 || wq[1].d !== w1)
            begin n_err++; $display("FAIL busy_write1 got %h:%h want 21:%h", wq[1].a, wq[1].d, w1); end
      end
      n_cmp++; if (bus.words_loaded !== 9'd2 || tmo !== 0)
         begin n_err++; $display("FAIL busy_loaded got %0d (tmo %0d) want 2 (0)", bus.words_loaded, tmo); end
   endtask

   task automatic test_random_sessions();
      for (int s = 0; s < 7; s++) begin
         logic [7:0] base = 8'($urandom);
         int cnt = (s == 6) ? 256 : $urandom_range(6, 1);
         int d0 = done_cnt, bad = 0, lat = 0;
         wq.delete(); wl.delete(); tmo = 0;
         for (int i = 0; i < cnt; i++) wl.push_back($urandom);
         run_session(base, 9'(cnt), (s == 6) ? 0 : 2);
         n_cmp++; if (wq.size() !== cnt) begin n_err++; $display("FAIL rand%0d_nwrites got %0d want %0d", s, wq.size(), cnt); end
         else begin
            foreach (wq[i]) begin
               if (wq[i].a !== 8'((int'(base) + i) % 256) || wq[i].d !== wl[i]) bad++;
               if (wq[i].c !== wq[i].l + 1) lat++;
            end
            n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rand%0d_data got %0d bad words want 0", s, bad); end
            n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL rand%0d_latency got %0d late writes want 0", s, lat); end
         end
         n_cmp++; if (bus.words_loaded !== 9'(cnt) || done_cnt - d0 !== 1 || tmo !== 0)
            begin n_err++; $display("FAIL rand%0d_status got loaded %0d done %0d tmo %0d want %0d 1 0",
                                    s, bus.words_loaded, done_cnt - d0, tmo, cnt); end
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0;
      bus.byte_in = '0; bus.byte_valid = 1'b0;
      test_reset();
      test_single_word();
      test_wrap();
      test_stall();
      test_zero_count();
      test_reset_mid_word();
      test_start_while_busy();
      test_random_sessions();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
